ps2_key_event: RTL and testbench

Converts the raw PS/2 scan-code byte stream from the keyboard receiver into discrete key press/release events for game logic. It sits directly downstream of the PS/2 receiver, in parallel with the UART debug path. The parser resolves `E0` (extended) and `F0` (break) prefixes, discards Pause (`E1`) sequences and keyboard housekeeping bytes, and queues events in a small FIFO with a valid/ready output. It also keeps a level bitmap of eight game keys.

---
 rtl/ps2_key_event_if.sv | 25 ++
 rtl/ps2_key_event.sv | 195 +++++++++++++++++++
 tb/tb_ps2_key_event.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_event_if.sv
// Event output channel of ps2_key_event: valid/ready handshake plus the
// head-of-FIFO event fields {code, ext, rel}.
interface ps2_key_event_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_rel;

    modport master (
        output ev_valid,
        output ev_code,
        output ev_ext,
        output ev_rel,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_code,
        input  ev_ext,
        input  ev_rel,
        output ev_ready
    );
endinterface

// File: rtl/ps2_key_event.sv
// PS/2 scan-code parser: turns the receiver byte stream into key press/release
// events (E0 extended and F0 break prefixes resolved, Pause E1 sequences and
// housekeeping bytes discarded), queues them in a small FIFO presented on a
// valid/ready channel, and keeps a level bitmap of eight game keys.
// Optional feature macro: REPEAT_FILTER_EN suppresses typematic repeat makes
// of mapped keys whose held bit is already set.
module ps2_key_event #(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            key_byte,
    input  logic                  key_flag,
    ps2_key_event_if.master       ev,
    output logic [7:0]            held,
    output logic                  overflow
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXTBRK, SKIP} state_t;

    state_t        state;
    state_t        next_state;
    logic [2:0]    skip_cnt;
    logic [2:0]    next_skip;
    logic          flag_q;
    logic          strobe;
    logic          emit;
    logic          emit_ext;
    logic          emit_rel;
    logic          slot_hit;
    logic [2:0]    slot_idx;
    logic          suppress;
    logic          push;
    logic          pop;
    logic          full;
    logic          accept;
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [9:0]    mem [DEPTH];

    // Keyboard self-test, echo, ack, resend and error bytes carry no key.
    function automatic logic is_noise(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
               (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
    endfunction

    // Maps {ext, code} onto a held-bitmap slot: returns {hit, index}.
    function automatic logic [3:0] key_slot(input logic ext, input logic [7:0] code);
        case ({ext, code})
            9'h01D:  key_slot = 4'b1000;
            9'h01C:  key_slot = 4'b1001;
            9'h01B:  key_slot = 4'b1010;
            9'h023:  key_slot = 4'b1011;
            9'h029:  key_slot = 4'b1100;
            9'h05A:  key_slot = 4'b1101;
            9'h16B:  key_slot = 4'b1110;
            9'h174:  key_slot = 4'b1111;
            default: key_slot = 4'b0000;
        endcase
    endfunction

    assign strobe = key_flag & ~flag_q;

    // Parser state, skip counter and strobe edge-detect register.
    always_ff @(posedge clk) begin
        flag_q <= key_flag;
        if (rst) begin
            state    <= IDLE;
            skip_cnt <= 3'd0;
        end else begin
            state    <= next_state;
            skip_cnt <= next_skip;
        end
    end

    // Prefix tracking: next parser state for the byte arriving this cycle.
    always_comb begin
        next_state = state;
        next_skip  = skip_cnt;
        if (strobe) begin
            case (state)
                IDLE: begin
                    if (key_byte == 8'hE0) begin
                        next_state = EXT;
                    end else if (key_byte == 8'hF0) begin
                        next_state = BRK;
                    end else if (key_byte == 8'hE1) begin
                        next_state = SKIP;
                        next_skip  = 3'd7;
                    end
                end
                EXT: begin
                    if (key_byte == 8'hF0) begin
                        next_state = EXTBRK;
                    end else if (key_byte != 8'hE0) begin
                        next_state = IDLE;
                    end
                end
                BRK, EXTBRK: begin
                    if (key_byte != 8'hF0) begin
                        next_state = IDLE;
                    end
                end
                SKIP: begin
                    next_skip = skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) begin
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Event emission: which byte completes a make or release, and its flags.
    always_comb begin
        emit     = 1'b0;
        emit_ext = 1'b0;
        emit_rel = 1'b0;
        if (strobe) begin
            case (state)
                IDLE: begin
                    emit = (key_byte != 8'hE0) && (key_byte != 8'hF0) &&
                           (key_byte != 8'hE1) && !is_noise(key_byte);
                end
                EXT: begin
                    emit     = (key_byte != 8'hF0) && (key_byte != 8'hE0);
                    emit_ext = 1'b1;
                end
                BRK: begin
                    emit     = (key_byte != 8'hF0);
                    emit_rel = 1'b1;
                end
                EXTBRK: begin
                    emit     = (key_byte != 8'hF0);
                    emit_ext = 1'b1;
                    emit_rel = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign {slot_hit, slot_idx} = key_slot(emit_ext, key_byte);

`ifdef REPEAT_FILTER_EN
    assign suppress = emit && !emit_rel && slot_hit && held[slot_idx];
`else
    assign suppress = 1'b0;
`endif

    assign push   = emit && !suppress;
    assign pop    = ev.ev_valid && ev.ev_ready;
    assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign accept = push && (!full || pop);

    // Event FIFO storage and pointers; a pop frees the slot for a same-cycle push.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (accept) begin
                mem[wptr[AW-1:0]] <= {emit_ext, emit_rel, key_byte};
                wptr              <= wptr + (AW+1)'(1);
            end
            if (pop) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end

    // Key level map follows every emitted event; overflow latches dropped events.
    always_ff @(posedge clk) begin
        if (rst) begin
            held     <= 8'h00;
            overflow <= 1'b0;
        end else begin
            if (emit && slot_hit) begin
                held[slot_idx] <= !emit_rel;
            end
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign ev.ev_valid = (wptr != rptr);
    assign {ev.ev_ext, ev.ev_rel, ev.ev_code} = mem[rptr[AW-1:0]];

endmodule

// File: tb/tb_ps2_key_event.sv
// Self-checking bench for ps2_key_event: a directed vector table, hand-written
// multi-cycle corner cases and a randomized run against a queue-based model.
module tb_ps2_key_event;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] key_byte;
    logic       key_flag;
    logic [7:0] held;
    logic       overflow;

    ps2_key_event_if evif();

    ps2_key_event #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .key_byte (key_byte),
        .key_flag (key_flag),
        .ev       (evif),
        .held     (held),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: pending-prefix flags, remaining Pause bytes, event queue.
    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } ev_t;

    ev_t        mq[$];
    logic [7:0] m_held = 8'h00;
    logic       m_ovf = 1'b0;
    logic       m_prev = 1'b0;
    bit         m_ext = 1'b0;
    bit         m_brk = 1'b0;
    int         m_skip = 0;
    logic [8:0] key_map [8];

    typedef struct {
        logic [7:0] b;
        bit         pop;
        logic       valid;
        logic [7:0] code;
        logic       ext;
        logic       rel;
        logic [7:0] hld;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic modelEvent(input bit ext, input bit rel, input logic [7:0] code);
        int idx;
        bit sup;
        idx = -1;
        sup = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (key_map[i] == {ext, code}) idx = i;
        end
`ifdef REPEAT_FILTER_EN
        if (!rel && idx >= 0 && m_held[idx]) sup = 1'b1;
`endif
        if (idx >= 0) m_held[idx] = !rel;
        if (!sup) begin
            if (mq.size() < DEPTH) mq.push_back({ext, rel, code});
            else m_ovf = 1'b1;
        end
    endtask

    task automatic modelByte(input logic [7:0] b);
        if (m_skip > 0) begin
            m_skip--;
        end else if (m_brk) begin
            if (b != 8'hF0) begin
                modelEvent(m_ext, 1'b1, b);
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
        end else if (m_ext) begin
            if (b == 8'hF0) m_brk = 1'b1;
            else if (b != 8'hE0) begin
                modelEvent(1'b1, 1'b0, b);
                m_ext = 1'b0;
            end
        end else begin
            if (b == 8'hE0) m_ext = 1'b1;
            else if (b == 8'hF0) m_brk = 1'b1;
            else if (b == 8'hE1) m_skip = 7;
            else if (!(b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}))
                modelEvent(1'b0, 1'b0, b);
        end
    endtask

    // Drive one cycle of inputs, advance the model, step past the edge.
    task automatic applyStimulus(input logic r, input logic f, input logic [7:0] b, input logic rdy);
        rst            = r;
        key_flag       = f;
        key_byte       = b;
        evif.ev_ready  = rdy;
        if (r) begin
            mq.delete();
            m_held = 8'h00;
            m_ovf  = 1'b0;
            m_ext  = 1'b0;
            m_brk  = 1'b0;
            m_skip = 0;
        end else begin
            if (rdy && mq.size() > 0) void'(mq.pop_front());
            if (f && !m_prev) modelByte(b);
        end
        m_prev = f;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name);
        check({name, ".valid"}, 32'(evif.ev_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            check({name, ".head"}, 32'({evif.ev_ext, evif.ev_rel, evif.ev_code}), 32'(mq[0]));
        end
        check({name, ".held"}, 32'(held), 32'(m_held));
        check({name, ".overflow"}, 32'(overflow), 32'(m_ovf));
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic sendByte(input logic [7:0] b, input logic rdy);
        applyStimulus(1'b0, 1'b1, b, rdy);
        applyStimulus(1'b0, 1'b0, b, rdy);
    endtask

    task automatic addVec(input logic [7:0] b, input bit pop, input logic valid,
                          input logic [7:0] code, input logic ext, input logic rel,
                          input logic [7:0] hld);
        vec_t v;
        v.b = b; v.pop = pop; v.valid = valid; v.code = code;
        v.ext = ext; v.rel = rel; v.hld = hld;
        vecs.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] pool [14];
        logic [7:0] ovf_codes [5];
        int n;
        int exp_n;
        logic       f;
        logic [7:0] b;

        key_map   = '{9'h01D, 9'h01C, 9'h01B, 9'h023, 9'h029, 9'h05A, 9'h16B, 9'h174};
        pool      = '{8'hE0, 8'hF0, 8'hE1, 8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29,
                      8'h5A, 8'h6B, 8'h74, 8'hAA, 8'h00, 8'hFF};
        ovf_codes = '{8'h1C, 8'h1B, 8'h23, 8'h29, 8'h5A};

        rst = 1'b1; key_flag = 1'b0; key_byte = 8'h00; evif.ev_ready = 1'b0;

        // Directed table: byte, pop afterwards, then head/held expected after the strobe edge.
        addVec(8'h1D, 1, 1, 8'h1D, 0, 0, 8'h01);
        addVec(8'hF0, 0, 0, 8'h00, 0, 0, 8'h01);
        addVec(8'h1D, 1, 1, 8'h1D, 0, 1, 8'h00);
        addVec(8'hE0, 0, 0, 8'h00, 0, 0, 8'h00);
        addVec(8'h74, 1, 1, 8'h74, 1, 0, 8'h80);
        addVec(8'hE0, 0, 0, 8'h00, 0, 0, 8'h80);
        addVec(8'hF0, 0, 0, 8'h00, 0, 0, 8'h80);
        addVec(8'h74, 1, 1, 8'h74, 1, 1, 8'h00);
        addVec(8'h74, 1, 1, 8'h74, 0, 0, 8'h00);
        addVec(8'hAA, 0, 0, 8'h00, 0, 0, 8'h00);
        addVec(8'hE1, 0, 0, 8'h00, 0, 0, 8'h00);
        addVec(8'h14, 0, 0, 8'h00, 0, 0, 8'h00);
        addVec(8'h77, 0, 0, 8'h00, 0, 0, 8'h00);
        addVec(8'hE1, 0, 0, 8'h00, 0, 0, 8'h00);
        addVec(8'hF0, 0, 0, 8'h00, 0, 0, 8'h00);
        addVec(8'h14, 0, 0, 8'h00, 0, 0, 8'h00);
        addVec(8'hF0, 0, 0, 8'h00, 0, 0, 8'h00);
        addVec(8'h77, 0, 0, 8'h00, 0, 0, 8'h00);
        addVec(8'h29, 1, 1, 8'h29, 0, 0, 8'h10);

        doReset();
        check("reset.valid", 32'(evif.ev_valid), 32'(0));
        check("reset.head", 32'({evif.ev_ext, evif.ev_rel, evif.ev_code}), 32'(0));
        check("reset.held", 32'(held), 32'(0));
        check("reset.overflow", 32'(overflow), 32'(0));

        foreach (vecs[i]) begin
            applyStimulus(1'b0, 1'b1, vecs[i].b, 1'b0);
            check($sformatf("vec%0d.valid", i), 32'(evif.ev_valid), 32'(vecs[i].valid));
            if (vecs[i].valid) begin
                check($sformatf("vec%0d.code", i), 32'(evif.ev_code), 32'(vecs[i].code));
                check($sformatf("vec%0d.ext", i), 32'(evif.ev_ext), 32'(vecs[i].ext));
                check($sformatf("vec%0d.rel", i), 32'(evif.ev_rel), 32'(vecs[i].rel));
            end
            check($sformatf("vec%0d.held", i), 32'(held), 32'(vecs[i].hld));
            check($sformatf("vec%0d.overflow", i), 32'(overflow), 32'(0));
            applyStimulus(1'b0, 1'b0, vecs[i].b, vecs[i].pop);
        end

        // Overflow: five makes into a four-deep FIFO with the consumer stalled.
        doReset();
        for (int k = 0; k < 5; k++) sendByte(ovf_codes[k], 1'b0);
        check("ovf.valid", 32'(evif.ev_valid), 32'(1));
        check("ovf.overflow", 32'(overflow), 32'(1));
        check("ovf.held", 32'(held), 32'(8'h3E));
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ovf.drain%0d", k),
                  32'({evif.ev_valid, evif.ev_ext, evif.ev_rel, evif.ev_code}),
                  32'({1'b1, 1'b0, 1'b0, ovf_codes[k]}));
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        end
        check("ovf.empty", 32'(evif.ev_valid), 32'(0));

        // Push and pop on the same edge while full: both taken, no overflow.
        doReset();
        for (int k = 0; k < 4; k++) sendByte(ovf_codes[k], 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h5A, 1'b1);
        check("fullpp.overflow", 32'(overflow), 32'(0));
        for (int k = 1; k < 5; k++) begin
            check($sformatf("fullpp.drain%0d", k), 32'({evif.ev_valid, evif.ev_code}),
                  32'({1'b1, ovf_codes[k]}));
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        end
        check("fullpp.empty", 32'(evif.ev_valid), 32'(0));

        // A strobe held high for three cycles is one byte.
        doReset();
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 8'h1D, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h1D, 1'b0);
        check("longflag.head", 32'({evif.ev_valid, evif.ev_code}), 32'({1'b1, 8'h1D}));
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        check("longflag.single", 32'(evif.ev_valid), 32'(0));

        // Reset discards a pending E0 prefix.
        doReset();
        sendByte(8'hE0, 1'b0);
        doReset();
        sendByte(8'h6B, 1'b0);
        check("rstext.head", 32'({evif.ev_valid, evif.ev_ext, evif.ev_rel, evif.ev_code}),
              32'({1'b1, 1'b0, 1'b0, 8'h6B}));
        check("rstext.held", 32'(held), 32'(0));

        // A strobe already high when reset releases is not a new byte.
        applyStimulus(1'b1, 1'b1, 8'h1D, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h1D, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h1D, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h1D, 1'b0);
        check("rstflag.valid", 32'(evif.ev_valid), 32'(0));

        // Ready asserted with nothing queued does not disturb the next push.
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h23, 1'b1);
        check("readyfirst.head", 32'({evif.ev_valid, evif.ev_code}), 32'({1'b1, 8'h23}));
        applyStimulus(1'b0, 1'b0, 8'h23, 1'b1);
        check("readyfirst.empty", 32'(evif.ev_valid), 32'(0));

        // Typematic repeats of W followed by its release.
        doReset();
        sendByte(8'h1D, 1'b0);
        sendByte(8'h1D, 1'b0);
        sendByte(8'h1D, 1'b0);
        sendByte(8'hF0, 1'b0);
        sendByte(8'h1D, 1'b0);
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (evif.ev_valid) begin
                n++;
                applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
            end
        end
`ifdef REPEAT_FILTER_EN
        exp_n = 2;
`else
        exp_n = 4;
`endif
        check("repeat.count", 32'(n), 32'(exp_n));
        check("repeat.held", 32'(held), 32'(0));

        // Randomized run against the reference model.
        doReset();
        for (int k = 0; k < 3000; k++) begin
            f = ($urandom_range(0, 1) == 1);
            b = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pool[$urandom_range(0, 13)];
            applyStimulus(($urandom_range(0, 299) == 0), f, b, ($urandom_range(0, 2) == 0));
            checkOutput($sformatf("rand%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
